// File: rtl/dmem_access_ctrl.sv
// Data memory initiator: accepts one valid/ready request, holds memread/memwrite for WAIT_CYCLES, returns a valid/ready response.
// Build option DMEM_RANGE_CHECK_EN: addresses >= MEM_DEPTH bypass memory and respond with resp_err=1.
module dmem_access_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_DEPTH   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);
    // state  | meaning
    // IDLE   | req_ready high, no strobes, waiting for a request
    // ACCESS | memread or memwrite held with latched address/data
    // RESP   | resp_valid high, rdata/err held until resp_ready
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [3:0]      CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic              memread_q;
    logic              memwrite_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] writedata_q;

    logic accept;
    logic out_of_range;

    assign accept       = req_valid && req_ready_q;
    assign out_of_range = RANGE_CHECK && ({1'b0, req_addr} >= DEPTH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        write_q     <= req_write;
                        address_q   <= req_addr;
                        writedata_q <= req_wdata;
                        cnt_q       <= CNT_LOAD;
                        if (out_of_range) begin
                            // Rejected address never reaches the memory bank.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q    <= ACCESS;
                            memread_q  <= ~req_write;
                            memwrite_q <= req_write;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        memread_q    <= 1'b0;
                        memwrite_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= write_q ? '0 : readdata;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign address    = address_q;
    assign writedata  = writedata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: elapsed-cycle transaction model checked every cycle, directed literal cases, random traffic.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int W     = 3;
    localparam int DEPTH = 128;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          memread;
    logic          memwrite;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    dmem_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .memread(memread), .memwrite(memwrite), .address(address),
        .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    // Memory bank attached to the DUT, and the bench's own view of its contents.
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];
    assign readdata = memread ? mem_arr[address] : 32'hA5A5_A5A5;
    always @(posedge clk) if (rst_n && memwrite) mem_arr[address] <= writedata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: after acceptance the strobe covers ages 0..len-1, response from age len on.
    bit            m_up = 0, m_busy = 0, m_write = 0, m_err = 0;
    int            m_age = 0, m_len = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_up = 0; m_busy = 0; m_age = 0; m_err = 0;
        end else begin
            if (m_busy) begin
                if (m_age >= m_len && resp_ready) m_busy = 0;
                else m_age++;
            end else if (m_up && req_valid) begin
                m_busy  = 1;
                m_age   = 0;
                m_write = req_write;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_err   = RC && (int'(req_addr) >= DEPTH);
                m_len   = m_err ? 0 : W;
                m_rdata = (m_err || req_write) ? '0 : ref_mem[req_addr];
                if (!m_err && req_write) ref_mem[req_addr] = req_wdata;
            end
            m_up = 1;
        end
    end

    always @(negedge clk) begin
        bit exp_strobe, exp_resp;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_memread", memread, 0);
            chk("rst_memwrite", memwrite, 0);
            chk("rst_address", address, 0);
            chk("rst_writedata", writedata, 0);
        end else begin
            exp_strobe = m_busy && (m_age < m_len);
            exp_resp   = m_busy && (m_age >= m_len);
            chk("req_ready", req_ready, !m_busy && m_up);
            chk("resp_valid", resp_valid, exp_resp);
            chk("resp_err", resp_err, exp_resp && m_err);
            chk("memread", memread, exp_strobe && !m_write);
            chk("memwrite", memwrite, exp_strobe && m_write);
            if (exp_strobe) begin
                chk("address", address, m_addr);
                if (m_write) chk("writedata", writedata, m_wdata);
            end
            if (exp_resp) chk("resp_rdata", resp_rdata, m_rdata);
        end
    end

    task automatic run_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int hold,
                           output int strobes, output int lat, output logic [DW-1:0] rdata, output bit err);
        int budget;
        strobes = 0; lat = 0; rdata = '0; err = 0;
        @(negedge clk);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd; resp_ready = 0;
        budget = 50;
        while (!req_ready && budget > 0) begin @(negedge clk); budget--; end
        chk("accept_wait", budget > 0, 1);
        @(negedge clk);
        req_valid = 0; req_write = ~wr; req_addr = ~a; req_wdata = ~wd;
        budget = 50;
        while (!resp_valid && budget > 0) begin
            lat++;
            if (memread || memwrite) begin
                strobes++;
                chk("strobe_addr", address, a);
                chk("strobe_dir", memwrite, wr);
                if (wr) chk("strobe_wdata", writedata, wd);
            end
            @(negedge clk);
            budget--;
        end
        lat++;
        chk("resp_wait", budget > 0, 1);
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        chk("done_resp_valid", resp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        resp_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, l, budget;
        logic [DW-1:0] r;
        bit e;
        int acc_idx[$];

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[1] = 5;   ref_mem[1] = 5;
        mem_arr[2] = 17;  ref_mem[2] = 17;
        mem_arr[5] = 19;  ref_mem[5] = 19;
        mem_arr[200] = 32'h00C8_1234; ref_mem[200] = 32'h00C8_1234;

        #1;
        chk("por_req_ready", req_ready, 0);
        chk("por_memread", memread, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        chk("release_req_ready0", req_ready, 0);
        @(negedge clk);
        chk("release_req_ready1", req_ready, 1);

        run_req(0, 8'd2, 0, 0, s, l, r, e);
        chk("ld2_strobes", s, 3);
        chk("ld2_latency", l, 4);
        chk("ld2_rdata", r, 17);
        chk("ld2_err", e, 0);

        run_req(1, 8'd10, 32'hDEADBEEF, 0, s, l, r, e);
        chk("st10_strobes", s, 3);
        chk("st10_rdata", r, 0);
        run_req(0, 8'd10, 0, 0, s, l, r, e);
        chk("ld10_rdata", r, 32'hDEADBEEF);

        run_req(0, 8'd5, 0, 4, s, l, r, e);
        chk("bp5_rdata", r, 19);

`ifdef DMEM_RANGE_CHECK_EN
        run_req(0, 8'd200, 0, 0, s, l, r, e);
        chk("oor_strobes", s, 0);
        chk("oor_latency", l, 1);
        chk("oor_err", e, 1);
        chk("oor_rdata", r, 0);
`else
        run_req(0, 8'd200, 0, 0, s, l, r, e);
        chk("a200_strobes", s, 3);
        chk("a200_err", e, 0);
        chk("a200_rdata", r, 32'h00C8_1234);
`endif
        run_req(0, 8'd1, 0, 0, s, l, r, e);
        chk("ld1_rdata", r, 5);
        chk("ld1_err", e, 0);

        // Continuous requests with resp_ready high: acceptances W+2 edges apart.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 8'd1; resp_ready = 1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (req_ready) acc_idx.push_back(i);
        end
        chk("b2b_count_ok", acc_idx.size() >= 2, 1);
        if (acc_idx.size() >= 2) chk("b2b_spacing", acc_idx[1] - acc_idx[0], 5);
        req_valid = 0;
        repeat (8) @(negedge clk);
        resp_ready = 0;

        // Reset in the 2nd strobe cycle of a load.
        req_valid = 1; req_write = 0; req_addr = 8'd7;
        budget = 50;
        while (!req_ready && budget > 0) begin @(negedge clk); budget--; end
        chk("mid_accept_wait", budget > 0, 1);
        @(negedge clk);
        req_valid = 0;
        chk("mid_strobe1", memread, 1);
        @(negedge clk);
        chk("mid_strobe2", memread, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_memread", memread, 0);
        chk("mid_rst_address", address, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        @(negedge clk);
        #1 rst_n = 1;
        chk("mid_rel_ready0", req_ready, 0);
        resp_ready = 1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            chk("mid_no_resp", resp_valid, 0);
        end

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req_valid  = ($urandom_range(0, 3) != 0);
            req_write  = ($urandom_range(0, 1) != 0);
            req_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
            req_wdata  = $urandom;
            resp_ready = ($urandom_range(0, 2) != 0);
        end
        req_valid = 0; resp_ready = 1;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
